// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared SDRAM definitions used by the init sequencer and, later, by the
// refresh/access controller.
// Contents:
//   - command encodings, ordered {CS_N, RAS_N, CAS_N, WE_N}
//   - default mode-register word (burst 4, sequential, CL=3)
//   - init FSM state type and state constants
// -----------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    localparam logic [11:0] MODE_REG_DEFAULT = 12'h032;

    typedef logic [2:0] init_state_t;

    localparam init_state_t ST_WAIT200 = 3'd0;
    localparam init_state_t ST_PRE     = 3'd1;
    localparam init_state_t ST_PRE_W   = 3'd2;
    localparam init_state_t ST_REF     = 3'd3;
    localparam init_state_t ST_REF_W   = 3'd4;
    localparam init_state_t ST_MRS     = 3'd5;
    localparam init_state_t ST_MRS_W   = 3'd6;
    localparam init_state_t ST_DONE    = 3'd7;

endpackage

// File: rtl/sdram_init_seq_if.sv
// -----------------------------------------------------------------------------
// sdram_init_seq_if
// SDRAM command/address pin bundle.
//   master : driver of the pins (init sequencer, later the command mux)
//   slave  : observer of the pins (command mux input, SDRAM model)
// Signals: SD_CKE, SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N, SD_BA[1:0],
//          SD_A[ADDR_W-1:0]
// -----------------------------------------------------------------------------
interface sdram_init_seq_if #(
    parameter int ADDR_W = 12
);
    logic              SD_CKE;
    logic              SD_CS_N;
    logic              SD_RAS_N;
    logic              SD_CAS_N;
    logic              SD_WE_N;
    logic [1:0]        SD_BA;
    logic [ADDR_W-1:0] SD_A;

    modport master (
        output SD_CKE, SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N, SD_BA, SD_A
    );

    modport slave (
        input SD_CKE, SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N, SD_BA, SD_A
    );
endinterface

// File: rtl/sdram_wait_cnt.sv
// -----------------------------------------------------------------------------
// sdram_wait_cnt
// Loadable 8-bit down-counter with a zero flag. Holds at zero.
// Ports:
//   CLK        in   clock (rising edge)
//   RST_N      in   synchronous active-low reset (count -> 0)
//   i_load     in   load i_load_val (has priority over i_dec)
//   i_load_val in 8 value to load
//   i_dec      in   decrement by one when non-zero
//   o_zero     out  count is zero
// -----------------------------------------------------------------------------
module sdram_wait_cnt (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);
    logic [7:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != 8'd0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == 8'd0);
endmodule

// File: rtl/sdram_init_seq.sv
// -----------------------------------------------------------------------------
// sdram_init_seq
// SDRAM power-up initialisation sequencer: after the 200 us wait flag it
// issues PRECHARGE ALL, REF_NUM x AUTO REFRESH and LOAD MODE REGISTER, then
// raises INIT_DONE_o. REINIT_i in DONE restarts the sequence without the wait.
// Ports:
//   CLK              in   clock (rising edge)
//   RST_N            in   synchronous active-low reset
//   INIT_WAIT_200_i  in   power-up wait elapsed (sampled only in WAIT200)
//   REINIT_i         in   re-initialisation request (honoured only in DONE)
//   sd               if   SDRAM pins (master modport), all registered
//   INIT_DONE_o      out  sequence complete
// -----------------------------------------------------------------------------
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                T_RP     = 3,
    parameter int                T_RFC    = 9,
    parameter int                T_MRD    = 2,
    parameter int                REF_NUM  = 2,
    parameter logic [ADDR_W-1:0] MODE_REG = ADDR_W'(MODE_REG_DEFAULT)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INIT_WAIT_200_i,
    input  logic             REINIT_i,
    sdram_init_seq_if.master sd,
    output logic             INIT_DONE_o
);
    // The counter is loaded with T_x-1 on the edge that puts a command on the
    // pins; the next command is issued on the first edge that sees it at zero.
    // This gives exactly T_x-1 NOP cycles, and none when T_x=1.
    localparam logic [7:0]        LD_RP     = 8'(T_RP - 1);
    localparam logic [7:0]        LD_RFC    = 8'(T_RFC - 1);
    localparam logic [7:0]        LD_MRD    = 8'(T_MRD - 1);
    localparam logic [3:0]        REF_LAST  = 4'(REF_NUM);
    localparam logic [ADDR_W-1:0] A_PRE_ALL = ADDR_W'(1) << 10;

    init_state_t       r_state;
    logic              r_cke;
    logic [3:0]        r_cmd;
    logic [1:0]        r_ba;
    logic [ADDR_W-1:0] r_a;
    logic              r_done;
    logic [3:0]        r_ref_cnt;

    init_state_t       w_state_next;
    logic [3:0]        w_cmd_next;
    logic [ADDR_W-1:0] w_a_next;
    logic              w_done_next;
    logic [3:0]        w_ref_cnt_next;
    logic              w_ld;
    logic [7:0]        w_ld_val;
    logic              w_dec;
    logic              w_zero;

    sdram_wait_cnt u_wait_cnt (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Next-state logic also computes the pin values for the new state, so a
    // command is on the pins in the cycle right after its state is entered.
    always_comb begin
        w_state_next   = r_state;
        w_cmd_next     = CMD_NOP;
        w_a_next       = '0;
        w_done_next    = 1'b0;
        w_ref_cnt_next = r_ref_cnt;
        w_ld           = 1'b0;
        w_ld_val       = 8'd0;
        w_dec          = 1'b0;

        case (r_state)
            ST_WAIT200: begin
                w_cmd_next = CMD_INHIBIT;
                if (INIT_WAIT_200_i) begin
                    w_state_next   = ST_PRE;
                    w_cmd_next     = CMD_PRE;
                    w_a_next       = A_PRE_ALL;
                    w_ref_cnt_next = 4'd0;
                    w_ld           = 1'b1;
                    w_ld_val       = LD_RP;
                end
            end

            ST_PRE, ST_PRE_W: begin
                if (w_zero) begin
                    w_state_next   = ST_REF;
                    w_cmd_next     = CMD_REF;
                    w_ref_cnt_next = (r_ref_cnt < REF_LAST) ? r_ref_cnt + 4'd1 : r_ref_cnt;
                    w_ld           = 1'b1;
                    w_ld_val       = LD_RFC;
                end else begin
                    w_state_next = ST_PRE_W;
                    w_dec        = 1'b1;
                end
            end

            ST_REF, ST_REF_W: begin
                if (!w_zero) begin
                    w_state_next = ST_REF_W;
                    w_dec        = 1'b1;
                end else if (r_ref_cnt >= REF_LAST) begin
                    w_state_next = ST_MRS;
                    w_cmd_next   = CMD_LMR;
                    w_a_next     = MODE_REG;
                    w_ld         = 1'b1;
                    w_ld_val     = LD_MRD;
                end else begin
                    w_state_next   = ST_REF;
                    w_cmd_next     = CMD_REF;
                    w_ref_cnt_next = r_ref_cnt + 4'd1;
                    w_ld           = 1'b1;
                    w_ld_val       = LD_RFC;
                end
            end

            ST_MRS, ST_MRS_W: begin
                if (w_zero) begin
                    w_state_next = ST_DONE;
                    w_done_next  = 1'b1;
                end else begin
                    w_state_next = ST_MRS_W;
                    w_dec        = 1'b1;
                end
            end

            ST_DONE: begin
                w_done_next = 1'b1;
                if (REINIT_i) begin
                    w_state_next   = ST_PRE;
                    w_cmd_next     = CMD_PRE;
                    w_a_next       = A_PRE_ALL;
                    w_done_next    = 1'b0;
                    w_ref_cnt_next = 4'd0;
                    w_ld           = 1'b1;
                    w_ld_val       = LD_RP;
                end
            end

            default: begin
                w_state_next = ST_WAIT200;
                w_cmd_next   = CMD_INHIBIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state   <= ST_WAIT200;
            r_cke     <= 1'b0;
            r_cmd     <= CMD_INHIBIT;
            r_ba      <= 2'b00;
            r_a       <= '0;
            r_done    <= 1'b0;
            r_ref_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_next;
            r_cke     <= 1'b1;
            r_cmd     <= w_cmd_next;
            r_ba      <= 2'b00;
            r_a       <= w_a_next;
            r_done    <= w_done_next;
            r_ref_cnt <= w_ref_cnt_next;
        end
    end

    assign sd.SD_CKE   = r_cke;
    assign sd.SD_CS_N  = r_cmd[3];
    assign sd.SD_RAS_N = r_cmd[2];
    assign sd.SD_CAS_N = r_cmd[1];
    assign sd.SD_WE_N  = r_cmd[0];
    assign sd.SD_BA    = r_ba;
    assign sd.SD_A     = r_a;
    assign INIT_DONE_o = r_done;
endmodule

// File: tb/tb_sdram_init_seq.sv
// -----------------------------------------------------------------------------
// tb_sdram_init_seq
// Directed bench for sdram_init_seq. dut_a uses default timing, dut_b uses
// T_RP=T_RFC=T_MRD=1 with REF_NUM=3. Expected command streams are written out
// as edge-number tables relative to edge 0 (first edge sampling the trigger).
// -----------------------------------------------------------------------------
module tb_sdram_init_seq;
    import sdram_pkg::*;

    logic CLK;
    logic rst_a, init_a, reinit_a, done_a;
    logic rst_b, init_b, reinit_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_init_seq_if #(.ADDR_W(12)) sd_a ();
    sdram_init_seq_if #(.ADDR_W(12)) sd_b ();

    sdram_init_seq dut_a (
        .CLK             (CLK),
        .RST_N           (rst_a),
        .INIT_WAIT_200_i (init_a),
        .REINIT_i        (reinit_a),
        .sd              (sd_a),
        .INIT_DONE_o     (done_a)
    );

    sdram_init_seq #(
        .T_RP    (1),
        .T_RFC   (1),
        .T_MRD   (1),
        .REF_NUM (3)
    ) dut_b (
        .CLK             (CLK),
        .RST_N           (rst_b),
        .INIT_WAIT_200_i (init_b),
        .REINIT_i        (reinit_b),
        .sd              (sd_b),
        .INIT_DONE_o     (done_b)
    );

    logic [3:0] cmd_a, cmd_b;
    assign cmd_a = {sd_a.SD_CS_N, sd_a.SD_RAS_N, sd_a.SD_CAS_N, sd_a.SD_WE_N};
    assign cmd_b = {sd_b.SD_CS_N, sd_b.SD_RAS_N, sd_b.SD_CAS_N, sd_b.SD_WE_N};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling or driving.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".cke"},  32'(sd_a.SD_CKE), 32'h0);
        chk({tag, ".cmd"},  32'(cmd_a),       32'hF);
        chk({tag, ".ba"},   32'(sd_a.SD_BA),  32'h0);
        chk({tag, ".a"},    32'(sd_a.SD_A),   32'h0);
        chk({tag, ".done"}, 32'(done_a),      32'h0);
        $display("%s reset cke=%0b cmd=%b done=%0b", tag, sd_a.SD_CKE, cmd_a, done_a);
    endtask

    task automatic chk_inhibit_a(input string tag);
        chk({tag, ".cke"},  32'(sd_a.SD_CKE), 32'h1);
        chk({tag, ".cmd"},  32'(cmd_a),       32'(CMD_INHIBIT));
        chk({tag, ".done"}, 32'(done_a),      32'h0);
        $display("%s wait cke=%0b cmd=%b", tag, sd_a.SD_CKE, cmd_a);
    endtask

    // Default timing: PRE@0, REF@3, REF@12, LMR@21, INIT_DONE from edge 23.
    // reinit_at: raise REINIT_i for the edge following step k.
    // pulse_init: drop INIT_WAIT_200_i right after edge 0.
    task automatic expect_seq_a(input string tag, input int n, input int reinit_at, input bit pulse_init);
        logic [3:0] exp_c;
        string      t;
        for (int k = 0; k < n; k++) begin
            step();
            case (k)
                0:       exp_c = CMD_PRE;
                3, 12:   exp_c = CMD_REF;
                21:      exp_c = CMD_LMR;
                default: exp_c = CMD_NOP;
            endcase
            t = $sformatf("%s.k%0d", tag, k);
            chk({t, ".cmd"},  32'(cmd_a),       32'(exp_c));
            chk({t, ".done"}, 32'(done_a),      32'(k >= 23));
            chk({t, ".cke"},  32'(sd_a.SD_CKE), 32'h1);
            if (k == 0) begin
                chk({t, ".pre_a"},  32'(sd_a.SD_A),  32'h400);
                chk({t, ".pre_ba"}, 32'(sd_a.SD_BA), 32'h0);
            end
            if (k == 21) begin
                chk({t, ".lmr_a"},  32'(sd_a.SD_A),  32'h032);
                chk({t, ".lmr_ba"}, 32'(sd_a.SD_BA), 32'h0);
            end
            $display("%s cmd=%b a=%h done=%0b", t, cmd_a, sd_a.SD_A, done_a);
            reinit_a = (k == reinit_at);
            if (pulse_init && k == 0) init_a = 1'b0;
        end
    endtask

    initial begin
        rst_a = 1'b0; init_a = 1'b0; reinit_a = 1'b0;
        rst_b = 1'b0; init_b = 1'b0; reinit_b = 1'b0;

        // 1: reset for 5 cycles, 10 cycles of wait, then the full sequence
        for (int i = 0; i < 5; i++) begin
            step();
            chk_reset_a($sformatf("t1.rst%0d", i));
        end
        rst_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_inhibit_a($sformatf("t1.w%0d", i));
        end
        init_a = 1'b1;
        expect_seq_a("t1", 30, -1, 1'b0);

        // 5a: REINIT_i in DONE restarts immediately
        reinit_a = 1'b1;
        expect_seq_a("t5a", 30, -1, 1'b0);

        // 5b: restart, then a REINIT_i pulse sampled on edge 7 (inside REF_W)
        reinit_a = 1'b1;
        expect_seq_a("t5b", 30, 6, 1'b0);

        // 4: reset on edge 6 (REF_W), INIT_WAIT_200_i still high afterwards
        reinit_a = 1'b1;
        expect_seq_a("t4pre", 6, -1, 1'b0);
        rst_a = 1'b0;
        step();
        chk_reset_a("t4.rst");
        rst_a = 1'b1;
        expect_seq_a("t4", 30, -1, 1'b0);

        // 6: one-cycle INIT_WAIT_200_i pulse
        rst_a  = 1'b0;
        init_a = 1'b0;
        step();
        chk_reset_a("t6.rst");
        rst_a = 1'b1;
        step();
        chk_inhibit_a("t6.w0");
        step();
        chk_inhibit_a("t6.w1");
        init_a = 1'b1;
        expect_seq_a("t6", 30, -1, 1'b1);

        // 3: back-to-back timing, three refreshes
        rst_b  = 1'b1;
        init_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] exp_c;
            string      t;
            step();
            case (k)
                0:       exp_c = CMD_PRE;
                1, 2, 3: exp_c = CMD_REF;
                4:       exp_c = CMD_LMR;
                default: exp_c = CMD_NOP;
            endcase
            t = $sformatf("t3.k%0d", k);
            chk({t, ".cmd"},  32'(cmd_b),  32'(exp_c));
            chk({t, ".done"}, 32'(done_b), 32'(k >= 5));
            if (k == 0) chk({t, ".pre_a"}, 32'(sd_b.SD_A), 32'h400);
            if (k == 4) chk({t, ".lmr_a"}, 32'(sd_b.SD_A), 32'h032);
            $display("%s cmd=%b a=%h done=%0b", t, cmd_b, sd_b.SD_A, done_b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_init_seq.md
# sdram_init_seq

SDRAM power-up initialisation sequencer. It consumes the 200 µs power-up-wait flag and then drives the JEDEC init command stream onto the SDRAM command/address pins:

- PRECHARGE ALL;
- REF_NUM × AUTO REFRESH;
- LOAD MODE REGISTER.

It then raises INIT_DONE_o, which hands the SDRAM pins to the controller's access/refresh path. It sits between the power-up wait counter and the SDRAM command mux.

## Interface

Parameters:
- ADDR_W, 12: SDRAM row/mode address width (≥11; A10 is the precharge-all bit).
- T_RP, 3: cycles from PRECHARGE to the next command (1..255).
- T_RFC, 9: cycles from AUTO REFRESH to the next command (1..255).
- T_MRD, 2: cycles from LOAD MODE REGISTER to INIT_DONE_o (1..255).
- REF_NUM, 2: number of AUTO REFRESH commands (1..15).
- MODE_REG, 12'h032: mode word (burst 4, sequential, CL=3), driven on SD_A during LMR.

Ports:
- CLK, input, 1: system clock. All logic is on the rising edge.
- RST_N, input, 1: one clock; reset is synchronous and active-low.
- INIT_WAIT_200_i, input, 1: power-up wait elapsed. Level signal; only its first rising level matters.
- REINIT_i, input, 1: request a full re-initialisation (no 200 µs wait). Honoured only in DONE.
- SD_CKE, output, 1: clock enable.
- SD_CS_N, SD_RAS_N, SD_CAS_N, SD_WE_N, outputs, 1 each: command pins.
- SD_BA, output, 2: bank address.
- SD_A, output, ADDR_W: address.
- INIT_DONE_o, output, 1: sequence complete; the SDRAM is ready for use.

## Operation

- All outputs are registered. Reset values:
  - SD_CKE=0;
  - SD_CS_N=SD_RAS_N=SD_CAS_N=SD_WE_N=1;
  - SD_BA=0, SD_A=0;
  - INIT_DONE_o=0.
- Command encodings {CS_N,RAS_N,CAS_N,WE_N}:
  - INHIBIT 1111;
  - NOP 0111;
  - PRECHARGE 0010;
  - AUTO REFRESH 0001;
  - LMR 0000.
- States: WAIT200, PRE, PRE_W, REF, REF_W, MRS, MRS_W, DONE. The reset state is WAIT200.
- WAIT200:
  - SD_CKE=1 from the first edge after reset release; the command is INHIBIT.
  - On an edge sampling INIT_WAIT_200_i=1 → PRE.
- PRE: one cycle of PRECHARGE with SD_A[10]=1, other SD_A bits 0, SD_BA=0. Load the wait counter with T_RP−1.
- PRE_W / REF_W / MRS_W:
  - Drive NOP while the counter decrements.
  - Leave when the counter reaches 0. A T_x=1 parameter skips the _W state entirely (back-to-back commands).
- REF:
  - One cycle of AUTO REFRESH. Increment the refresh count and load the counter with T_RFC−1.
  - After the REF_NUM-th refresh the wait exits to MRS; otherwise it exits to REF.
- MRS: one cycle of LMR with SD_A=MODE_REG, SD_BA=0. Load the counter with T_MRD−1.
- DONE:
  - Command NOP; INIT_DONE_o=1; SD_CKE=1.
  - REF_INIT_i=1 → INIT_DONE_o=0 and PRECHARGE on the next edge, with the refresh count cleared.
- REINIT_i is ignored in every state other than DONE.
- INIT_WAIT_200_i falling after it has been sampled high has no effect.
- The wait counter is 8 bits and counts down. The refresh counter is 4 bits and saturates at REF_NUM.

## Timing

- Command latency: a command appears on the pins in the cycle after the edge on which its state is entered.
- Edge numbering: edge 0 is the first edge sampling INIT_WAIT_200_i=1.
- Defaults (T_RP=3, T_RFC=9, T_MRD=2, REF_NUM=2):
  - PRECHARGE after edge 0;
  - REF after edge 3;
  - REF after edge 12;
  - LMR after edge 21;
  - INIT_DONE_o=1 after edge 23.
- General rule: a command loaded on edge e is followed by the next load on edge e+T_x, with exactly T_x−1 NOP cycles between them.
- Each command is exactly one cycle wide. INHIBIT is never emitted after WAIT200.
- RST_N low on any edge, including mid-wait: all outputs return to their reset values after that edge, and the FSM returns to WAIT200.
- RST_N low and REINIT_i together: reset wins.

## Structure

- Shared package sdram_pkg contains:
  - command encodings (CMD_INHIBIT, CMD_NOP, CMD_PRE, CMD_REF, CMD_LMR);
  - the default MODE_REG constant;
  - the FSM state typedef. This is reused later by the refresh/access controller.
- One natural sub-module, sdram_wait_cnt: a loadable 8-bit down-counter with a zero flag, shared with the future refresh timer.

## Test plan

1. Reset held for 5 cycles, INIT_WAIT_200_i raised 10 cycles later:
   - outputs are at reset values during reset; then CKE=1 with INHIBIT;
   - PRE/REF/REF/LMR follow edge 0 at edges 0/3/12/21; INIT_DONE_o rises after edge 23; every other cycle is NOP.
2. Command fields:
   - during PRE, SD_A=12'h400 and BA=0;
   - during LMR, SD_A=12'h032 and BA=0;
   - during REF and NOP, CS_N=0.
3. T_RP=1, T_RFC=1, T_MRD=1, REF_NUM=3: PRE, REF, REF, REF, LMR on consecutive cycles; INIT_DONE_o one cycle after LMR.
4. RST_N pulled low for 1 cycle in the REF_W between the two refreshes: reset values on the next cycle; with INIT_WAIT_200_i still 1, PRECHARGE follows one cycle after release and the full sequence repeats.
5. Re-initialisation:
   - REINIT_i pulsed in DONE → INIT_DONE_o=0 and PRECHARGE on the next cycle, full sequence repeated;
   - REINIT_i pulsed during REF_W → ignored, timing unchanged.
6. INIT_WAIT_200_i pulsed high for one cycle, then low: the sequence still completes; INIT_DONE_o stays 1.
